// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Holds the redirect-source and state encodings plus the instruction-size constants.
// Used by pc_redirect_arbiter and pc_fetch_sequencer.
package pc_seq_pkg;

    // Source of the most recent PC load, also driven out on redirect_src.
    typedef enum logic [1:0] {
        SRC_SEQ  = 2'd0,
        SRC_PRED = 2'd1,
        SRC_EX   = 2'd2,
        SRC_EXC  = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_e;

    localparam int unsigned INSN_BYTES = 4;
    // Low PC bits that must be zero for an aligned instruction address.
    localparam int unsigned ALIGN_LO_MASK = INSN_BYTES - 1;

endpackage

// File: rtl/pc_redirect_arbiter.sv
// Combinational next-PC selector: exc_req > ex > pred > stall > sequential +4.
// Latency: zero (purely combinational); the caller registers the result.
// Backpressure: stall only suppresses the sequential advance, never a redirect.
// Optional macro PC_SEQ_EXC_EN adds the exc_req input and the exception-vector source.
// Ports: enables/targets in; next_src, next_pc, redirect (a target was taken), advance (+4 taken) out.
module pc_redirect_arbiter
    import pc_seq_pkg::*;
#(
    parameter int unsigned     PC_W       = 32,
    parameter logic [PC_W-1:0] EXC_VECTOR = 'h80
) (
`ifdef PC_SEQ_EXC_EN
    input  logic            exc_req,
`endif
    input  logic            stall,
    input  logic [PC_W-1:0] pc_count,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_target_enable,
    input  logic [PC_W-1:0] pre_target,
    input  logic            pre_target_enable,
    output logic [1:0]      next_src,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect,
    output logic            advance
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(ALIGN_LO_MASK);

    always_comb begin
        next_src = SRC_SEQ;
        next_pc  = pc_count;
        redirect = 1'b0;
        advance  = 1'b0;
`ifdef PC_SEQ_EXC_EN
        if (exc_req) begin
            next_src = SRC_EXC;
            next_pc  = EXC_VECTOR & ALIGN_MASK;
            redirect = 1'b1;
        end else
`endif
        if (ex_target_enable) begin
            next_src = SRC_EX;
            next_pc  = ex_target & ALIGN_MASK;
            redirect = 1'b1;
        end else if (pre_target_enable) begin
            next_src = SRC_PRED;
            next_pc  = pre_target & ALIGN_MASK;
            redirect = 1'b1;
        end else if (!stall) begin
            // Natural modulo-2**PC_W wrap from the top of the address space to 0.
            next_pc = pc_count + PC_W'(INSN_BYTES);
            advance = 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner: registers pc_count/pc_valid/flushes/redirect_src from the arbiter's choice.
// Latency: one cycle from sampling edge to new PC; pc_valid low REDIRECT_BUBBLES cycles after a redirect.
// Backpressure: stall freezes sequential advance and bubble countdown; redirects are still taken.
// Optional macro PC_SEQ_EXC_EN adds the exc_req port (exception vector redirect).
// Ports: clk, reset (async high), stall, ex/pre targets+enables, [exc_req];
//        out pc_count, pc_valid, flush_if, flush_id, redirect_src (all registered).
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     PC_W             = 32,
    parameter logic [PC_W-1:0] RESET_PC         = '0,
    parameter logic [PC_W-1:0] EXC_VECTOR       = 'h80,
    parameter int unsigned     REDIRECT_BUBBLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_target_enable,
    input  logic [PC_W-1:0] pre_target,
    input  logic            pre_target_enable,
`ifdef PC_SEQ_EXC_EN
    input  logic            exc_req,
`endif
    output logic [PC_W-1:0] pc_count,
    output logic            pc_valid,
    output logic            flush_if,
    output logic            flush_id,
    output logic [1:0]      redirect_src
);

    state_e          state;
    logic [1:0]      bub_cnt;
    logic [1:0]      next_src;
    logic [PC_W-1:0] next_pc;
    logic            redirect;
    logic            advance;

    pc_redirect_arbiter #(
        .PC_W       (PC_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
`ifdef PC_SEQ_EXC_EN
        .exc_req           (exc_req),
`endif
        .stall             (stall),
        .pc_count          (pc_count),
        .ex_target         (ex_target),
        .ex_target_enable  (ex_target_enable),
        .pre_target        (pre_target),
        .pre_target_enable (pre_target_enable),
        .next_src          (next_src),
        .next_pc           (next_pc),
        .redirect          (redirect),
        .advance           (advance)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= BOOT;
            pc_count     <= RESET_PC;
            pc_valid     <= 1'b0;
            flush_if     <= 1'b0;
            flush_id     <= 1'b0;
            redirect_src <= SRC_SEQ;
            bub_cnt      <= 2'd0;
        end else begin
            // Flushes are single-cycle pulses unless re-armed by a redirect below.
            flush_if <= 1'b0;
            flush_id <= 1'b0;
            case (state)
                BOOT: begin
                    // First fetch is RESET_PC itself; any enables this edge are ignored.
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN, BUBBLE: begin
                    if (redirect) begin
                        pc_count     <= next_pc;
                        redirect_src <= next_src;
                        flush_if     <= 1'b1;
                        // A predicted redirect happens in decode, so ID/EX still holds good work.
                        flush_id     <= (next_src != SRC_PRED);
                        if (REDIRECT_BUBBLES > 0) begin
                            state    <= BUBBLE;
                            bub_cnt  <= 2'(REDIRECT_BUBBLES);
                            pc_valid <= 1'b0;
                        end else begin
                            state    <= RUN;
                            pc_valid <= 1'b1;
                        end
                    end else if (state == BUBBLE) begin
                        // PC is parked on the redirect target; only the countdown moves.
                        if (!stall) begin
                            if (bub_cnt <= 2'd1) begin
                                bub_cnt  <= 2'd0;
                                state    <= RUN;
                                pc_valid <= 1'b1;
                            end else begin
                                bub_cnt <= bub_cnt - 2'd1;
                            end
                        end
                    end else if (advance) begin
                        pc_count     <= next_pc;
                        redirect_src <= SRC_SEQ;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
